r2r_wavegen: RTL

Parametrised successor to the R2R DAC controller. It drives a WIDTH-bit code into the level shifters and R2R ladder. A programmable clock divider sets the sample rate. The code comes either from the external data bus or from an internal generator: sawtooth, triangle or square, with a programmable step size. It sits between the 1v8 digital domain (ui_in/uio_in) and the dac_drive instances, and exposes sample-tick and period-wrap strobes on uo_out.

---
 rtl/r2r_wavegen_if.sv | 25 ++
 rtl/r2r_wavegen.sv | 131 +++++++++++++
 2 files changed

// File: rtl/r2r_wavegen_if.sv
// r2r_wavegen_if: control bus and DAC code/strobe outputs of the R2R waveform generator.
// Ports: ena, mode, data, load_divider, load_step (controller -> generator);
//        r2r_out, cnt_zero, wrap (generator -> ladder / observers). No handshake: level controls.
interface r2r_wavegen_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic             load_divider;
    logic             load_step;
    logic [WIDTH-1:0] r2r_out;
    logic             cnt_zero;
    logic             wrap;

    modport master (
        output ena, mode, data, load_divider, load_step,
        input  r2r_out, cnt_zero, wrap
    );

    modport slave (
        input  ena, mode, data, load_divider, load_step,
        output r2r_out, cnt_zero, wrap
    );
endinterface

// File: rtl/r2r_wavegen.sv
// r2r_wavegen: divided-rate DAC code source (ext bus, sawtooth, triangle, square) for an R2R ladder.
// Latency: generator code and strobes registered on the tick edge; ext data visible 1 cycle after its tick edge.
// Backpressure: none; ena=0 freezes divider/generator/outputs. Ports: clk, n_rst, bus (slave modport).
module r2r_wavegen #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 0
) (
    input  logic           clk,
    input  logic           n_rst,
    r2r_wavegen_if.slave   bus
);
    typedef enum logic [1:0] {MODE_EXT = 2'b00, MODE_SAW = 2'b01, MODE_TRI = 2'b10, MODE_SQR = 2'b11} mode_t;
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    localparam logic [DIV_WIDTH-1:0] RST_DIV  = DIV_WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0]     CODE_MAX = {WIDTH{1'b1}};

    logic [DIV_WIDTH-1:0] div_reg, div_nxt;
    logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]     step_reg, step_nxt;
    logic [WIDTH-1:0]     phase, phase_nxt;
    logic [WIDTH-1:0]     out_q, out_nxt;
    logic                 cz_q, cz_nxt;
    logic                 wrap_q, wrap_nxt;
    dir_t                 dir, dir_nxt;
    mode_t                mode_q, mode_nxt;

    logic                 tick;
    logic [WIDTH:0]       sum;

    // A divider load suppresses the tick so the new period starts cleanly.
    assign tick = bus.ena && (cnt == '0) && !bus.load_divider;
    assign sum  = {1'b0, phase} + {1'b0, step_reg};

    always_comb begin
        div_nxt   = div_reg;
        cnt_nxt   = cnt;
        step_nxt  = step_reg;
        phase_nxt = phase;
        out_nxt   = out_q;
        dir_nxt   = dir;
        mode_nxt  = mode_q;
        cz_nxt    = 1'b0;
        wrap_nxt  = 1'b0;

        if (bus.load_divider) begin
            div_nxt = bus.data[DIV_WIDTH-1:0];
            cnt_nxt = bus.data[DIV_WIDTH-1:0];
        end else if (bus.ena) begin
            cnt_nxt = (cnt == '0) ? div_reg : cnt - DIV_WIDTH'(1);
        end

        if (bus.load_step) begin
            step_nxt = bus.data;
        end

        // A mode change restarts the waveform and swallows a coincident tick.
        if (mode_t'(bus.mode) != mode_q) begin
            mode_nxt  = mode_t'(bus.mode);
            phase_nxt = '0;
            dir_nxt   = DIR_UP;
            out_nxt   = '0;
        end else if (tick) begin
            cz_nxt = 1'b1;
            case (mode_q)
                MODE_EXT: begin
                    out_nxt = bus.data;
                end
                MODE_SAW: begin
                    phase_nxt = sum[WIDTH-1:0];
                    out_nxt   = sum[WIDTH-1:0];
                    wrap_nxt  = sum[WIDTH];
                end
                MODE_SQR: begin
                    phase_nxt = sum[WIDTH-1:0];
                    out_nxt   = {WIDTH{sum[WIDTH-1]}};
                    wrap_nxt  = sum[WIDTH];
                end
                default: begin
                    // Triangle clamps at both rails so a large step still hits 0 and MAX.
                    if (dir == DIR_UP) begin
                        if (sum >= {1'b0, CODE_MAX}) begin
                            phase_nxt = CODE_MAX;
                            dir_nxt   = DIR_DOWN;
                        end else begin
                            phase_nxt = sum[WIDTH-1:0];
                        end
                    end else begin
                        if (phase <= step_reg) begin
                            phase_nxt = '0;
                            dir_nxt   = DIR_UP;
                            wrap_nxt  = 1'b1;
                        end else begin
                            phase_nxt = phase - step_reg;
                        end
                    end
                    out_nxt = phase_nxt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_reg  <= RST_DIV;
            cnt      <= RST_DIV;
            step_reg <= WIDTH'(1);
            phase    <= '0;
            out_q    <= '0;
            dir      <= DIR_UP;
            mode_q   <= MODE_EXT;
            cz_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            div_reg  <= div_nxt;
            cnt      <= cnt_nxt;
            step_reg <= step_nxt;
            phase    <= phase_nxt;
            out_q    <= out_nxt;
            dir      <= dir_nxt;
            mode_q   <= mode_nxt;
            cz_q     <= cz_nxt;
            wrap_q   <= wrap_nxt;
        end
    end

    assign bus.r2r_out  = out_q;
    assign bus.cnt_zero = cz_q;
    assign bus.wrap     = wrap_q;
endmodule
